// File: rtl/lsu_pkg.sv
// Shared opcodes, FSM state codes and op classification helpers for the LSU.
package lsu_pkg;

  localparam logic [5:0] OP_LB  = 6'd19;
  localparam logic [5:0] OP_LH  = 6'd20;
  localparam logic [5:0] OP_LW  = 6'd21;
  localparam logic [5:0] OP_LBU = 6'd22;
  localparam logic [5:0] OP_LHU = 6'd23;
  localparam logic [5:0] OP_SB  = 6'd24;
  localparam logic [5:0] OP_SH  = 6'd25;
  localparam logic [5:0] OP_SW  = 6'd26;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WB   = 3'd2;
  localparam logic [2:0] ST_FIN  = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  // Fields of an accepted op that must survive the whole sequence.
  typedef struct packed {
    logic [5:0] op;
    logic [1:0] boff;
    logic [4:0] rd;
  } lsu_cap_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op >= OP_LB) && (op <= OP_LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  function automatic logic misaligned(input logic [5:0] op, input logic [1:0] a);
    case (op)
      OP_LH, OP_LHU, OP_SH: return a[0];
      OP_LW, OP_SW:         return a != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Core-side op handshake plus word-aligned memory bus and regfile writeback.
interface lsu_ctrl_if;
  logic        start;
  logic [5:0]  op;
  logic [31:0] addr;
  logic [31:0] sdata;
  logic [4:0]  rd;
  logic        busy;
  logic        done;
  logic        err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;

  modport slave (
    input  start, op, addr, sdata, rd, mem_ack, mem_rdata,
    output busy, done, err, mem_req, mem_addr, mem_wmask, mem_wdata,
           rf_we, rf_rd, rf_wdata
  );

  modport master (
    output start, op, addr, sdata, rd, mem_ack, mem_rdata,
    input  busy, done, err, mem_req, mem_addr, mem_wmask, mem_wdata,
           rf_we, rf_rd, rf_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store replication + write mask, load extract + extend.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [5:0]  i_op,
  input  logic [1:0]  i_boff,
  input  logic [31:0] i_sdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata
);

  logic [31:0] w_shift;
  assign w_shift = i_rdata >> {i_boff, 3'b000};

  // Lane selection keyed by opcode; loads never assert write enables.
  always_comb begin
    o_wmask = 4'b0000;
    o_wdata = 32'h0;
    o_ldata = 32'h0;
    case (i_op)
      OP_SB: begin
        o_wmask = 4'b0001 << i_boff;
        o_wdata = {4{i_sdata[7:0]}};
      end
      OP_SH: begin
        o_wmask = i_boff[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_sdata[15:0]}};
      end
      OP_SW: begin
        o_wmask = 4'b1111;
        o_wdata = i_sdata;
      end
      OP_LB:  o_ldata = {{24{w_shift[7]}}, w_shift[7:0]};
      OP_LBU: o_ldata = {24'h0, w_shift[7:0]};
      OP_LH:  o_ldata = {{16{w_shift[15]}}, w_shift[15:0]};
      OP_LHU: o_ldata = {16'h0, w_shift[15:0]};
      OP_LW:  o_ldata = i_rdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: accepts one op, runs a req/ack memory access with a
// timeout, then pulses done (with regfile writeback for loads or err).
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  lsu_ctrl_if.slave  bus
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [2:0]  r_state;
  lsu_cap_t    r_cap;
  logic [15:0] r_cnt;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_wmask;
  logic [31:0] r_mem_wdata;
  logic        r_done;
  logic        r_err;
  logic        r_rf_we;
  logic [4:0]  r_rf_rd;
  logic [31:0] r_rf_wdata;

  logic [2:0]  w_nxt;
  logic        w_accept;
  logic        w_ld_ack;
  logic [5:0]  w_op;
  logic [1:0]  w_boff;
  logic [3:0]  w_wmask;
  logic [31:0] w_wdata;
  logic [31:0] w_ldata;

  // One aligner serves both phases: live inputs while idle (store lanes are
  // registered on accept), captured op/offset afterwards (load extract on ack).
  assign w_op   = (r_state == ST_IDLE) ? bus.op        : r_cap.op;
  assign w_boff = (r_state == ST_IDLE) ? bus.addr[1:0] : r_cap.boff;

  lsu_align u_align (
    .i_op    (w_op),
    .i_boff  (w_boff),
    .i_sdata (bus.sdata),
    .i_rdata (bus.mem_rdata),
    .o_wmask (w_wmask),
    .o_wdata (w_wdata),
    .o_ldata (w_ldata)
  );

  assign w_accept = (r_state == ST_IDLE) && bus.start &&
                    (is_load(bus.op) || is_store(bus.op));
  assign w_ld_ack = (r_state == ST_REQ) && bus.mem_ack && is_load(r_cap.op);

  // Next-state: misaligned ops skip the bus entirely; ack beats timeout on the last cycle.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_nxt = misaligned(bus.op, bus.addr[1:0]) ? ST_ERR : ST_REQ;
      ST_REQ: begin
        if (bus.mem_ack)          w_nxt = is_load(r_cap.op) ? ST_WB : ST_FIN;
        else if (r_cnt == TO_LAST) w_nxt = ST_ERR;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  // State, capture and timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cap   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_accept) r_cap <= '{op: bus.op, boff: bus.addr[1:0], rd: bus.rd};
      r_cnt <= (r_state == ST_REQ) ? r_cnt + 16'd1 : 16'd0;
    end
  end

  // Memory-side outputs: loaded on entry to REQ, held through it, zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wmask <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_req <= (w_nxt == ST_REQ);
      if (w_nxt != ST_REQ) begin
        r_mem_addr  <= '0;
        r_mem_wmask <= '0;
        r_mem_wdata <= '0;
      end else if (w_accept) begin
        r_mem_addr  <= {bus.addr[31:2], 2'b00};
        r_mem_wmask <= w_wmask;
        r_mem_wdata <= w_wdata;
      end
    end
  end

  // Completion pulses and regfile writeback, all derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rf_we    <= 1'b0;
      r_rf_rd    <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_done     <= (w_nxt == ST_WB) || (w_nxt == ST_FIN) || (w_nxt == ST_ERR);
      r_err      <= (w_nxt == ST_ERR);
      r_rf_we    <= (w_nxt == ST_WB) && (r_cap.rd != 5'd0);
      r_rf_rd    <= (w_nxt == ST_WB) ? r_cap.rd : 5'd0;
      r_rf_wdata <= w_ld_ack ? w_ldata : 32'h0;
    end
  end

  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wmask = r_mem_wmask;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.rf_we     = r_rf_we;
  assign bus.rf_rd     = r_rf_rd;
  assign bus.rf_wdata  = r_rf_wdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized + directed bench for lsu_ctrl against a byte-level reference model.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  lsu_ctrl_if bus ();

  lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---- reference model (byte view of the word bus) ----
  function automatic int m_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      default:              return 4;
    endcase
  endfunction

  function automatic bit m_isld(input logic [5:0] op);
    return op == OP_LB || op == OP_LH || op == OP_LW || op == OP_LBU || op == OP_LHU;
  endfunction

  function automatic bit m_mis(input logic [5:0] op, input logic [31:0] a);
    return (a % m_size(op)) != 0;
  endfunction

  function automatic logic [3:0] m_wmask(input logic [5:0] op, input logic [31:0] a);
    logic [3:0] m = '0;
    int b = int'(a[1:0]);
    for (int i = 0; i < 4; i++) m[i] = (i >= b) && (i < b + m_size(op));
    return m;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] s);
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = s[8*(i % m_size(op)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_ld(input logic [5:0] op, input logic [31:0] a,
                                       input logic [31:0] rdata);
    logic [31:0] w = rdata >> (8 * int'(a[1:0]));
    case (op)
      OP_LB:  return 32'($signed(w[7:0]));
      OP_LBU: return 32'(w[7:0]);
      OP_LH:  return 32'($signed(w[15:0]));
      OP_LHU: return 32'(w[15:0]);
      default: return rdata;
    endcase
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"},  32'(bus.busy), 0);
    chk({tag, "_done"},  32'(bus.done | bus.err), 0);
    chk({tag, "_req"},   32'(bus.mem_req), 0);
    chk({tag, "_wmask"}, 32'(bus.mem_wmask), 0);
    chk({tag, "_rfwe"},  32'(bus.rf_we), 0);
  endtask

  // Run one valid op; dly = REQ cycles before ack (>= TO means never acked).
  // With poke, start is re-asserted in the done cycle and must be ignored.
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                        input logic [4:0] r, input logic [31:0] rdata, input int dly,
                        input bit poke);
    bit mis = m_mis(op, a);
    bit got = 0;
    int nreq = 0;
    int k;
    int exp_k, exp_n;
    bit exp_err, exp_we;
    bus.start = 1; bus.op = op; bus.addr = a; bus.sdata = sd; bus.rd = r;
    @(posedge clk); #1;
    bus.start = 0;
    for (k = 1; k <= TO + 8; k++) begin
      if (bus.done) begin got = 1; break; end
      if (bus.mem_req) begin
        if (nreq == 0) begin
          chk("mem_addr", bus.mem_addr, {a[31:2], 2'b00});
          chk("mem_wmask", 32'(bus.mem_wmask), m_isld(op) ? 32'h0 : 32'(m_wmask(op, a)));
          if (!m_isld(op)) chk("mem_wdata", bus.mem_wdata, m_wdata(op, sd));
        end
        bus.mem_ack   = (nreq == dly);
        bus.mem_rdata = (nreq == dly) ? rdata : $urandom;
        nreq++;
      end
      @(posedge clk); #1;
      bus.mem_ack = 0;
    end
    exp_err = mis || (dly >= TO);
    exp_k   = mis ? 1 : (dly < TO ? dly + 2 : TO + 1);
    exp_n   = mis ? 0 : (dly < TO ? dly + 1 : TO);
    exp_we  = !exp_err && m_isld(op) && (r != 0);
    chk("done_seen", 32'(got), 1);
    chk("latency", k, exp_k);
    chk("req_cycles", nreq, exp_n);
    chk("err", 32'(bus.err), 32'(exp_err));
    chk("req_at_done", 32'(bus.mem_req), 0);
    chk("rf_we", 32'(bus.rf_we), 32'(exp_we));
    if (exp_we) chk("rf_rd", 32'(bus.rf_rd), 32'(r));
    if (!exp_err && m_isld(op)) chk("rf_wdata", bus.rf_wdata, m_ld(op, a, rdata));
    if (poke) begin
      bus.start = 1; bus.op = OP_LW; bus.addr = 32'h40; bus.rd = 5'd1;
    end
    @(posedge clk); #1;
    bus.start = 0;
    chk("idle_after", 32'(bus.busy), 0);
    chk("done_clr", 32'(bus.done), 0);
  endtask

  task automatic bad_op(input logic [5:0] op);
    bus.start = 1; bus.op = op; bus.addr = 32'h100;
    @(posedge clk); #1;
    bus.start = 0;
    chk("badop_busy", 32'(bus.busy), 0);
    @(posedge clk); #1;
    chk("badop_done", 32'(bus.done), 0);
  endtask

  initial begin
    logic [5:0]  op;
    logic [31:0] a;
    bus.start = 0; bus.op = 0; bus.addr = 0; bus.sdata = 0; bus.rd = 0;
    bus.mem_ack = 0; bus.mem_rdata = 0;
    #12;
    chk_quiet("rst");
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    chk_quiet("post_rst");

    // directed cases
    run_op(OP_LW,  32'h100, 32'h0, 5'd5, 32'hDEADBEEF, 0, 0);
    run_op(OP_LB,  32'h103, 32'h0, 5'd7, 32'h80112233, 0, 0);
    run_op(OP_LBU, 32'h103, 32'h0, 5'd7, 32'h80112233, 1, 0);
    run_op(OP_SH,  32'h206, 32'h1234ABCD, 5'd3, 32'h0, 0, 0);
    run_op(OP_LW,  32'h101, 32'h0, 5'd4, 32'h0, 0, 0);
    run_op(OP_SB,  32'h101, 32'hA5, 5'd0, 32'h0, 2, 0);
    run_op(OP_LH,  32'h102, 32'h0, 5'd9, 32'h8001_0000, 3, 0);
    run_op(OP_SW,  32'h300, 32'h11223344, 5'd0, 32'h0, 99, 0);
    run_op(OP_LW,  32'h400, 32'h0, 5'd0, 32'hCAFEF00D, 0, 1);
    bad_op(6'd27);
    bad_op(6'd18);

    // reset mid-request, then a stale ack in IDLE
    bus.start = 1; bus.op = OP_LW; bus.addr = 32'h500; bus.rd = 5'd6;
    @(posedge clk); #1;
    bus.start = 0;
    chk("pre_rst_req", 32'(bus.mem_req), 1);
    rst_n = 0;
    #1;
    chk_quiet("midrst");
    chk("midrst_addr", bus.mem_addr, 0);
    @(posedge clk); #1;
    rst_n = 1;
    bus.mem_ack = 1; bus.mem_rdata = 32'h12345678;
    @(posedge clk); #1;
    bus.mem_ack = 0;
    chk_quiet("stale_ack");
    @(posedge clk); #1;
    chk_quiet("stale_ack2");

    // randomized ops
    for (int n = 0; n < 80; n++) begin
      op = 6'(19 + $urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = (m_size(op) == 4) ? 2'b00 :
                                               (m_size(op) == 2) ? {a[1], 1'b0} : a[1:0];
      if ($urandom_range(0, 9) == 0) bad_op(6'($urandom_range(27, 63)));
      run_op(op, a, $urandom, 5'($urandom), $urandom, $urandom_range(0, 5),
             1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
